// File: rtl/mem_io_ctrl_if.sv
// CPU-side request/Ready bus between the SLC-3 MAR/MDR and the memory/IO controller.
// Latency: none; this is a plain signal bundle.
// Backpressure: the CPU holds Mem_Rd/Mem_Wr until the controller pulses Ready for one cycle.
interface mem_io_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) ();
   logic              Mem_Rd;
   logic              Mem_Wr;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] Data_from_CPU;
   logic [DATA_W-1:0] Data_to_CPU;
   logic              Ready;

   // CPU side: issues requests, consumes read data and the completion pulse
   modport master (
      output Mem_Rd, Mem_Wr, ADDR, Data_from_CPU,
      input  Data_to_CPU, Ready
   );

   // Controller side
   modport slave (
      input  Mem_Rd, Mem_Wr, ADDR, Data_from_CPU,
      output Data_to_CPU, Ready
   );
endinterface

// File: rtl/mem_io_ctrl.sv
// Memory/IO controller: CPU MAR/MDR to external SRAM with programmable wait states, plus switch/hex IO.
// Latency: Ready is high WAIT_CYCLES+1 cycles after an SRAM request is accepted, 1 cycle for IO.
// Backpressure: requests are sampled only in IDLE; the CPU holds its request until the Ready pulse.
module mem_io_ctrl #(
   parameter int                DATA_W      = 16,
   parameter int                ADDR_W      = 16,
   parameter int                SW_W        = 10,
   parameter int                N_HEX       = 4,
   parameter int                WAIT_CYCLES = 2,
   parameter logic [ADDR_W-1:0] IO_ADDR     = 16'hFFFF
) (
   input  logic                 Clk,
   input  logic                 Reset,
   mem_io_ctrl_if.slave         cpu,
   input  logic [SW_W-1:0]      Switches,
   output logic [4*N_HEX-1:0]   Hex_Digits,
   output logic [ADDR_W-1:0]    SRAM_ADDR,
   output logic                 SRAM_OE_N,
   output logic                 SRAM_WE_N,
   input  logic [DATA_W-1:0]    Data_from_SRAM,
   output logic [DATA_W-1:0]    Data_to_SRAM
);

   // A one-bit counter is kept even for WAIT_CYCLES=1 so the vector is never zero-width.
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             is_io;

   assign is_io     = (cpu.ADDR == IO_ADDR);
   // DONE lasts exactly one cycle, so decoding it gives the single-cycle completion pulse.
   assign cpu.Ready = (state == ST_DONE);

   // Request sequencing, SRAM strobe/address/data registers and the IO latches.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state           <= ST_IDLE;
         wait_cnt        <= '0;
         cpu.Data_to_CPU <= '0;
         Hex_Digits      <= '0;
         SRAM_ADDR       <= '0;
         Data_to_SRAM    <= '0;
         SRAM_OE_N       <= 1'b1;
         SRAM_WE_N       <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu.Mem_Wr || cpu.Mem_Rd) begin
                  if (is_io) begin
                     // IO never touches the SRAM pins; write wins over read.
                     if (cpu.Mem_Wr)
                        Hex_Digits <= cpu.Data_from_CPU[4*N_HEX-1:0];
                     else
                        cpu.Data_to_CPU <= DATA_W'(Switches);
                     state <= ST_DONE;
                  end else begin
                     // Latched copies keep the SRAM bus stable while the CPU bus may wander.
                     SRAM_ADDR    <= cpu.ADDR;
                     Data_to_SRAM <= cpu.Data_from_CPU;
                     wait_cnt     <= CNT_W'(WAIT_CYCLES - 1);
                     SRAM_WE_N    <= !cpu.Mem_Wr;
                     SRAM_OE_N    <= cpu.Mem_Wr;
                     state        <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (wait_cnt == '0) begin
                  // An active output enable marks this access as a read.
                  if (!SRAM_OE_N)
                     cpu.Data_to_CPU <= Data_from_SRAM;
                  SRAM_OE_N <= 1'b1;
                  SRAM_WE_N <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               SRAM_OE_N <= 1'b1;
               SRAM_WE_N <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: measured per transaction in clock edges from the accepting edge to the Ready pulse.
// Backpressure: the bench acts as the CPU, holding each request until Ready is observed.
module tb_mem_io_ctrl;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   mem_io_ctrl_if #(.DATA_W(16), .ADDR_W(16)) cif0 ();
   mem_io_ctrl_if #(.DATA_W(16), .ADDR_W(16)) cif1 ();
   mem_io_ctrl_if #(.DATA_W(16), .ADDR_W(16)) cif4 ();

   logic [9:0]  Switches;
   logic [15:0] hex0, hex1, hex4;
   logic [15:0] sa0, sa1, sa4;
   logic        oe0, oe1, oe4, we0, we1, we4;
   logic [15:0] dfs0, dfs1, dfs4;
   logic [15:0] dts0, dts1, dts4;

   // SRAM model for the main instance: 16 words, indexed by the low address nibble.
   logic [15:0] sram_mem [16];
   assign dfs0 = oe0 ? 16'hDEAD : sram_mem[sa0[3:0]];
   assign dfs1 = 16'h1111;
   assign dfs4 = 16'h4444;

   mem_io_ctrl #(.WAIT_CYCLES(2)) u0 (
      .Clk(Clk), .Reset(Reset), .cpu(cif0), .Switches(Switches), .Hex_Digits(hex0),
      .SRAM_ADDR(sa0), .SRAM_OE_N(oe0), .SRAM_WE_N(we0), .Data_from_SRAM(dfs0), .Data_to_SRAM(dts0));
   mem_io_ctrl #(.WAIT_CYCLES(1)) u1 (
      .Clk(Clk), .Reset(Reset), .cpu(cif1), .Switches(Switches), .Hex_Digits(hex1),
      .SRAM_ADDR(sa1), .SRAM_OE_N(oe1), .SRAM_WE_N(we1), .Data_from_SRAM(dfs1), .Data_to_SRAM(dts1));
   mem_io_ctrl #(.WAIT_CYCLES(4)) u4 (
      .Clk(Clk), .Reset(Reset), .cpu(cif4), .Switches(Switches), .Hex_Digits(hex4),
      .SRAM_ADDR(sa4), .SRAM_OE_N(oe4), .SRAM_WE_N(we4), .Data_from_SRAM(dfs4), .Data_to_SRAM(dts4));

   int n_cmp  = 0;
   int n_fail = 0;

   // Transaction-level reference state
   logic [15:0] ref_mem [16];
   logic [15:0] ref_dcpu;
   logic [15:0] ref_hex;

   // Drive one CPU request on the main instance and observe it until Ready (bounded).
   task automatic do_xfer(input logic wr, input logic rd, input logic [15:0] addr, input logic [15:0] data,
                          output int lat, output int oe_cnt, output int we_cnt, output logic bus_ok);
      logic done;
      lat = 0; oe_cnt = 0; we_cnt = 0; bus_ok = 1'b1; done = 1'b0;
      @(negedge Clk);
      cif0.Mem_Wr = wr; cif0.Mem_Rd = rd; cif0.ADDR = addr; cif0.Data_from_CPU = data;
      for (int c = 0; c < 40 && !done; c++) begin
         @(posedge Clk);
         lat++;
         #1;
         cif0.ADDR          = 16'($urandom);
         cif0.Data_from_CPU = 16'($urandom);
         @(negedge Clk);
         if (!oe0) oe_cnt++;
         if (!we0) begin
            we_cnt++;
            sram_mem[sa0[3:0]] = dts0;
         end
         if ((!oe0 || !we0) && (sa0 !== addr || (!we0 && dts0 !== data))) bus_ok = 1'b0;
         if (cif0.Ready === 1'b1) begin
            cif0.Mem_Rd = 1'b0; cif0.Mem_Wr = 1'b0; done = 1'b1;
         end
      end
      if (!done) begin
         lat = -1; cif0.Mem_Rd = 1'b0; cif0.Mem_Wr = 1'b0;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      n_cmp++; if (cif0.Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cif0.Ready); end
      n_cmp++; if (cif0.Data_to_CPU !== 16'h0) begin n_fail++; $display("FAIL reset_dcpu: got %h want 0000", cif0.Data_to_CPU); end
      n_cmp++; if (hex0 !== 16'h0) begin n_fail++; $display("FAIL reset_hex: got %h want 0000", hex0); end
      n_cmp++; if (sa0 !== 16'h0 || dts0 !== 16'h0) begin n_fail++; $display("FAIL reset_sram_bus: got addr %h data %h want 0000 0000", sa0, dts0); end
      n_cmp++; if (oe0 !== 1'b1 || we0 !== 1'b1) begin n_fail++; $display("FAIL reset_strobes: got oe %b we %b want 1 1", oe0, we0); end
      Reset = 1'b0;
      ref_dcpu = 16'h0; ref_hex = 16'h0;
   endtask

   task automatic test_sram_read();
      int lat, oc, wc; logic ok;
      sram_mem[0] = 16'hBEEF; ref_mem[0] = 16'hBEEF;
      do_xfer(1'b0, 1'b1, 16'h0010, 16'h0000, lat, oc, wc, ok);
      ref_dcpu = ref_mem[0];
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
      n_cmp++; if (oc !== 2 || wc !== 0) begin n_fail++; $display("FAIL rd_strobes: got oe %0d we %0d want 2 0", oc, wc); end
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_bus: SRAM address not held at 0010"); end
      n_cmp++; if (cif0.Data_to_CPU !== ref_dcpu) begin n_fail++; $display("FAIL rd_data: got %h want %h", cif0.Data_to_CPU, ref_dcpu); end
   endtask

   task automatic test_sram_write();
      int lat, oc, wc; logic ok;
      do_xfer(1'b1, 1'b0, 16'h1234, 16'hA5A5, lat, oc, wc, ok);
      ref_mem[4] = 16'hA5A5;
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", lat); end
      n_cmp++; if (wc !== 2 || oc !== 0) begin n_fail++; $display("FAIL wr_strobes: got we %0d oe %0d want 2 0", wc, oc); end
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_bus: SRAM address/data not 1234/A5A5 while WE_N low"); end
      n_cmp++; if (sram_mem[4] !== ref_mem[4]) begin n_fail++; $display("FAIL wr_mem: got %h want %h", sram_mem[4], ref_mem[4]); end
      n_cmp++; if (cif0.Data_to_CPU !== ref_dcpu) begin n_fail++; $display("FAIL wr_dcpu_kept: got %h want %h", cif0.Data_to_CPU, ref_dcpu); end
   endtask

   task automatic test_io();
      int lat, oc, wc; logic ok;
      Switches = 10'h3FF;
      do_xfer(1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, oc, wc, ok);
      ref_dcpu = 16'h03FF;
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL io_rd_latency: got %0d want 1", lat); end
      n_cmp++; if (oc !== 0 || wc !== 0) begin n_fail++; $display("FAIL io_rd_strobes: got oe %0d we %0d want 0 0", oc, wc); end
      n_cmp++; if (cif0.Data_to_CPU !== ref_dcpu) begin n_fail++; $display("FAIL io_rd_data: got %h want %h", cif0.Data_to_CPU, ref_dcpu); end
      do_xfer(1'b1, 1'b0, 16'hFFFF, 16'h1A2B, lat, oc, wc, ok);
      ref_hex = 16'h1A2B;
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL io_wr_latency: got %0d want 1", lat); end
      n_cmp++; if (oc !== 0 || wc !== 0) begin n_fail++; $display("FAIL io_wr_strobes: got oe %0d we %0d want 0 0", oc, wc); end
      n_cmp++; if (hex0 !== ref_hex) begin n_fail++; $display("FAIL io_wr_hex: got %h want %h", hex0, ref_hex); end
      n_cmp++; if (cif0.Data_to_CPU !== ref_dcpu) begin n_fail++; $display("FAIL io_wr_dcpu_kept: got %h want %h", cif0.Data_to_CPU, ref_dcpu); end
   endtask

   task automatic test_priority();
      int lat, oc, wc; logic ok;
      do_xfer(1'b1, 1'b1, 16'h0020, 16'h7E57, lat, oc, wc, ok);
      ref_mem[0] = 16'h7E57;
      n_cmp++; if (wc !== 2 || oc !== 0) begin n_fail++; $display("FAIL prio_strobes: got we %0d oe %0d want 2 0", wc, oc); end
      n_cmp++; if (sram_mem[0] !== ref_mem[0]) begin n_fail++; $display("FAIL prio_mem: got %h want %h", sram_mem[0], ref_mem[0]); end
      n_cmp++; if (cif0.Data_to_CPU !== ref_dcpu) begin n_fail++; $display("FAIL prio_dcpu_kept: got %h want %h", cif0.Data_to_CPU, ref_dcpu); end
   endtask

   task automatic test_reset_mid_access();
      int lat, oc, wc, rdy_seen; logic ok;
      @(negedge Clk);
      cif0.Mem_Wr = 1'b1; cif0.ADDR = 16'h0030; cif0.Data_from_CPU = 16'h5555;
      @(posedge Clk);
      @(negedge Clk);
      cif0.Mem_Wr = 1'b0;
      n_cmp++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we_active: got %b want 0", we0); end
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      ref_dcpu = 16'h0; ref_hex = 16'h0;
      n_cmp++; if (cif0.Ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 0", cif0.Ready); end
      n_cmp++; if (we0 !== 1'b1 || oe0 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_strobes: got we %b oe %b want 1 1", we0, oe0); end
      n_cmp++; if (hex0 !== ref_hex) begin n_fail++; $display("FAIL rst_mid_hex: got %h want %h", hex0, ref_hex); end
      n_cmp++; if (cif0.Data_to_CPU !== ref_dcpu) begin n_fail++; $display("FAIL rst_mid_dcpu: got %h want %h", cif0.Data_to_CPU, ref_dcpu); end
      rdy_seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge Clk);
         if (cif0.Ready === 1'b1) rdy_seen++;
      end
      n_cmp++; if (rdy_seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_ready: got %0d pulses want 0", rdy_seen); end
      Switches = 10'h155;
      do_xfer(1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, oc, wc, ok);
      ref_dcpu = 16'h0155;
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL rst_mid_idle: IO latency got %0d want 1", lat); end
      n_cmp++; if (cif0.Data_to_CPU !== ref_dcpu) begin n_fail++; $display("FAIL rst_mid_io_data: got %h want %h", cif0.Data_to_CPU, ref_dcpu); end
   endtask

   task automatic test_back_to_back();
      int q0[$], q1[$], q4[$];
      int b2b;
      int f0, s0, f1, s1, f4, s4;
      b2b = 0;
      @(negedge Clk);
      cif0.Mem_Rd = 1'b1; cif0.ADDR = 16'h0040;
      cif1.Mem_Rd = 1'b1; cif1.ADDR = 16'h0040; cif1.Data_from_CPU = 16'h0;
      cif4.Mem_Rd = 1'b1; cif4.ADDR = 16'h0040; cif4.Data_from_CPU = 16'h0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (cif0.Ready === 1'b1) begin if (q0.size() > 0 && q0[q0.size()-1] == c - 1) b2b++; q0.push_back(c); end
         if (cif1.Ready === 1'b1) begin if (q1.size() > 0 && q1[q1.size()-1] == c - 1) b2b++; q1.push_back(c); end
         if (cif4.Ready === 1'b1) begin if (q4.size() > 0 && q4[q4.size()-1] == c - 1) b2b++; q4.push_back(c); end
      end
      cif0.Mem_Rd = 1'b0; cif1.Mem_Rd = 1'b0; cif4.Mem_Rd = 1'b0;
      repeat (8) @(negedge Clk);
      ref_dcpu = ref_mem[0];
      f0 = (q0.size() > 0) ? q0[0] : -1; s0 = (q0.size() > 1) ? q0[1] : -1;
      f1 = (q1.size() > 0) ? q1[0] : -1; s1 = (q1.size() > 1) ? q1[1] : -1;
      f4 = (q4.size() > 0) ? q4[0] : -1; s4 = (q4.size() > 1) ? q4[1] : -1;
      // First Ready WAIT+1 edges after accept; a held request re-accepts after one IDLE cycle.
      n_cmp++; if (f0 !== 3 || s0 !== 7) begin n_fail++; $display("FAIL b2b_w2_ready_at: got %0d,%0d want 3,7", f0, s0); end
      n_cmp++; if (f1 !== 2 || s1 !== 5) begin n_fail++; $display("FAIL b2b_w1_ready_at: got %0d,%0d want 2,5", f1, s1); end
      n_cmp++; if (f4 !== 5 || s4 !== 11) begin n_fail++; $display("FAIL b2b_w4_ready_at: got %0d,%0d want 5,11", f4, s4); end
      n_cmp++; if (b2b !== 0) begin n_fail++; $display("FAIL b2b_adjacent_ready: got %0d want 0", b2b); end
      n_cmp++; if (cif0.Data_to_CPU !== ref_dcpu) begin n_fail++; $display("FAIL b2b_w2_data: got %h want %h", cif0.Data_to_CPU, ref_dcpu); end
      n_cmp++; if (cif1.Data_to_CPU !== 16'h1111) begin n_fail++; $display("FAIL b2b_w1_data: got %h want 1111", cif1.Data_to_CPU); end
      n_cmp++; if (cif4.Data_to_CPU !== 16'h4444) begin n_fail++; $display("FAIL b2b_w4_data: got %h want 4444", cif4.Data_to_CPU); end
      n_cmp++; if (sa1 !== 16'h0040 || sa4 !== 16'h0040) begin n_fail++; $display("FAIL b2b_sram_addr: got %h %h want 0040 0040", sa1, sa4); end
      n_cmp++; if (we1 !== 1'b1 || we4 !== 1'b1 || oe1 !== 1'b1 || oe4 !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_strobes: got we %b%b oe %b%b want 11 11", we1, we4, oe1, oe4); end
      n_cmp++; if (hex1 !== 16'h0 || hex4 !== 16'h0 || dts1 !== 16'h0 || dts4 !== 16'h0) begin n_fail++; $display("FAIL b2b_side_outputs: got hex %h %h wdata %h %h want all 0000", hex1, hex4, dts1, dts4); end
   endtask

   task automatic test_random();
      int lat, oc, wc; logic ok;
      logic io, wr, rd;
      logic [3:0]  idx;
      logic [15:0] addr, data;
      int exp_lat, exp_oc, exp_wc;
      for (int t = 0; t < 40; t++) begin
         io   = ($urandom_range(0, 4) == 0);
         wr   = 1'($urandom_range(0, 1));
         rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         idx  = 4'($urandom);
         addr = io ? 16'hFFFF : {4'h0, 8'($urandom), idx};
         data = 16'($urandom);
         Switches = 10'($urandom);
         exp_lat = io ? 1 : 3;
         exp_oc  = (!io && !wr) ? 2 : 0;
         exp_wc  = (!io && wr) ? 2 : 0;
         if (io && wr)        ref_hex = data;
         else if (io)         ref_dcpu = {6'b0, Switches};
         else if (wr)         ref_mem[idx] = data;
         else                 ref_dcpu = ref_mem[idx];
         do_xfer(wr, rd, addr, data, lat, oc, wc, ok);
         n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, lat, exp_lat); end
         n_cmp++; if (oc !== exp_oc || wc !== exp_wc) begin n_fail++; $display("FAIL rnd%0d_strobes: got oe %0d we %0d want %0d %0d", t, oc, wc, exp_oc, exp_wc); end
         n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_bus: SRAM bus not held at %h", t, addr); end
         n_cmp++; if (cif0.Data_to_CPU !== ref_dcpu) begin n_fail++; $display("FAIL rnd%0d_dcpu: got %h want %h", t, cif0.Data_to_CPU, ref_dcpu); end
         n_cmp++; if (hex0 !== ref_hex) begin n_fail++; $display("FAIL rnd%0d_hex: got %h want %h", t, hex0, ref_hex); end
         if (!io && wr) begin
            n_cmp++; if (sram_mem[idx] !== ref_mem[idx]) begin n_fail++; $display("FAIL rnd%0d_mem: got %h want %h", t, sram_mem[idx], ref_mem[idx]); end
         end
      end
   endtask

   initial begin
      Reset = 1'b1;
      Switches = 10'h0;
      cif0.Mem_Rd = 1'b0; cif0.Mem_Wr = 1'b0; cif0.ADDR = 16'h0; cif0.Data_from_CPU = 16'h0;
      cif1.Mem_Rd = 1'b0; cif1.Mem_Wr = 1'b0; cif1.ADDR = 16'h0; cif1.Data_from_CPU = 16'h0;
      cif4.Mem_Rd = 1'b0; cif4.Mem_Wr = 1'b0; cif4.ADDR = 16'h0; cif4.Data_from_CPU = 16'h0;
      for (int i = 0; i < 16; i++) begin
         sram_mem[i] = 16'(i * 16'h0101 + 16'h3000);
         ref_mem[i]  = 16'(i * 16'h0101 + 16'h3000);
      end
      ref_dcpu = 16'h0;
      ref_hex  = 16'h0;
      test_reset();
      test_sram_read();
      test_sram_write();
      test_io();
      test_priority();
      test_reset_mid_access();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
